// File: rtl/bcd_scan_driver_if.sv
// Bus between the display controller and bcd_scan_driver: load handshake,
// conversion status and the multiplexed digit outputs.
interface bcd_scan_driver_if #(
  parameter int BIN_W = 14,
  parameter int NDIG  = 4
);
  // load is honoured only while busy==0; once accepted, value is captured and
  // later changes to value or load have no effect until done has pulsed.
  logic [BIN_W-1:0] value;
  logic             load;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [3:0]       digit_code;
  logic [NDIG-1:0]  digit_sel_n;
  logic             disp_en_n;
  logic [1:0]       state_dbg;

  modport master (
    output value, load,
    input  busy, done, overflow, digit_code, digit_sel_n, disp_en_n, state_dbg
  );

  modport slave (
    input  value, load,
    output busy, done, overflow, digit_code, digit_sel_n, disp_en_n, state_dbg
  );
endinterface

// File: rtl/bcd_scan_driver.sv
// Binary to BCD (serial double-dabble) plus digit scan multiplexer for a 7-seg decoder.
// Optional macro LEAD_ZERO_BLANK_EN: blank leading zero digits above digit 0.
module bcd_scan_driver #(
  parameter int BIN_W    = 14,
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic            clk,
  input  logic            reset_n,
  bcd_scan_driver_if.slave bus
);

  localparam int BCD_W  = 4 * NDIG;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t             state_q;
  logic [BIN_W-1:0]   shift_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               sticky_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               ovf_q;
  logic [BCD_W-1:0]   digits_q;

  logic [BCD_W-1:0]   adj_bcd;
  logic [BCD_W-1:0]   bcd_nxt;
  logic [BIN_W-1:0]   shift_nxt;
  logic               shift_out;
  logic               sticky_nxt;
  logic [BCD_W-1:0]   commit_digits;
`ifdef LEAD_ZERO_BLANK_EN
  logic               lead;
`endif

  // One double-dabble step: add-3 correction, then shift {bcd,shift} left.
  always_comb begin
    adj_bcd = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj_bcd[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {shift_out, bcd_nxt, shift_nxt} = {adj_bcd, shift_q, 1'b0};
    sticky_nxt = sticky_q | shift_out;
  end

  always_comb begin
    commit_digits = sticky_nxt ? {NDIG{4'hA}} : bcd_nxt;
`ifdef LEAD_ZERO_BLANK_EN
    lead = 1'b1;
    if (!sticky_nxt) begin
      for (int i = NDIG - 1; i >= 1; i--) begin
        if (lead && bcd_nxt[4*i +: 4] == 4'd0) commit_digits[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
  end

  // The last shift and the commit share one edge so digits and done appear
  // together; the COMMIT state is the visible done cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bcd_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      digits_q <= {NDIG{4'hF}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, COMMIT: begin
          if (bus.load) begin
            shift_q  <= bus.value;
            bcd_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end else begin
            state_q  <= IDLE;
          end
        end
        SHIFT: begin
          shift_q  <= shift_nxt;
          bcd_q    <= bcd_nxt;
          sticky_q <= sticky_nxt;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            digits_q <= commit_digits;
            ovf_q    <= sticky_nxt;
            state_q  <= COMMIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [SLOT_W-1:0] slot_q;
  logic [IDX_W-1:0]  idx_q;
  logic [NDIG-1:0]   sel_n_q;
  logic [3:0]        code_q;
  logic              disp_en_n_q;
  logic              slot_wrap;
  logic [SLOT_W-1:0] slot_d;
  logic [IDX_W-1:0]  idx_d;

  always_comb begin
    slot_wrap = (slot_q == SLOT_W'(SCAN_DIV - 1));
    slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d     = idx_q;
    if (slot_wrap) idx_d = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + 1'b1;
  end

  // Select and code are registered from the same index so they move together;
  // the display is blanked for the first cycle of every slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q      <= '0;
      idx_q       <= '0;
      sel_n_q     <= ~NDIG'(1);
      code_q      <= 4'hF;
      disp_en_n_q <= 1'b1;
    end else begin
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      sel_n_q     <= ~(NDIG'(1) << idx_d);
      code_q      <= digits_q[idx_d*4 +: 4];
      disp_en_n_q <= (slot_d == '0);
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.overflow    = ovf_q;
  assign bus.digit_code  = code_q;
  assign bus.digit_sel_n = sel_n_q;
  assign bus.disp_en_n   = disp_en_n_q;
  assign bus.state_dbg   = state_q;

endmodule
